// File: rtl/fft_frame_ctrl.sv
// Frame sequencer around a streaming FFT: captures 2^N samples, drains the FFT
// output into a RAM, then reads the RAM back in natural order at a slow hold rate.
module fft_frame_ctrl #(
  parameter int unsigned N    = 9,
  parameter logic [23:0] fdiv = 24'd400000,
  parameter logic [15:0] TMO  = 16'd4096
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         start,
  input  logic         cont,
  input  logic         din_valid,
  input  logic         fft_ovalid,
  input  logic [N-1:0] fft_oidx,
  output logic         en_fft,
  output logic [N-1:0] cnt_fft,
  output logic         ram_wea,
  output logic [N-1:0] ram_addr,
  output logic         enout,
  output logic [N-1:0] cnt_ram_out,
  output logic         busy,
  output logic         frame_done,
  output logic         ovf,
  output logic         tmo_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N:0]   rd_cnt_q, rd_cnt_d;
  logic [23:0]  hold_cnt_q, hold_cnt_d;
  logic [15:0]  tmo_cnt_q, tmo_cnt_d;
  logic         en_fft_d, enout_d, frame_done_d, ovf_d, tmo_err_d;
  logic [N-1:0] cnt_fft_d, cnt_ram_out_d;

  // The FFT writes its output in bit-reversed order; reading through the
  // reversed address yields natural-order bins.
  function automatic logic [N-1:0] bit_rev(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < int'(N); i++) r[i] = v[N-1-i];
    return r;
  endfunction

  assign busy = (state_q != S_IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_cnt_d      = rd_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    ovf_d         = ovf;
    tmo_err_d     = tmo_err;
    en_fft_d      = 1'b0;
    cnt_fft_d     = cnt_fft;
    frame_done_d  = 1'b0;
    enout_d       = (state_q == S_READOUT) && !rd_cnt_q[N];
    cnt_ram_out_d = rd_cnt_q[N-1:0];
    ram_wea       = 1'b0;
    ram_addr      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start || cont) begin
          state_d   = S_CAPTURE;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          tmo_err_d = 1'b0;
        end
      end

      S_CAPTURE: begin
        if (start) ovf_d = 1'b1;
        if (din_valid) begin
          en_fft_d  = 1'b1;
          cnt_fft_d = cnt_q;
          cnt_d     = cnt_q + N'(1);
          if (&cnt_q) begin
            state_d   = S_DRAIN;
            tmo_cnt_d = '0;
          end
        end
      end

      S_DRAIN: begin
        if (start || din_valid) ovf_d = 1'b1;
        ram_wea  = fft_ovalid;
        ram_addr = fft_oidx;
        if (fft_ovalid) begin
          tmo_cnt_d = '0;
          if (&fft_oidx) begin
            state_d    = S_READOUT;
            rd_cnt_d   = '0;
            hold_cnt_d = '0;
          end
        end else if (tmo_cnt_q == TMO - 16'd1) begin
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end

      S_READOUT: begin
        if (start || din_valid) ovf_d = 1'b1;
        ram_addr = bit_rev(rd_cnt_q[N-1:0]);
        if (rd_cnt_q[N]) begin
          frame_done_d = 1'b1;
          // Re-entering capture in continuous mode is a new frame accept, which
          // wins over a sample dropped on this same cycle.
          if (cont) begin
            state_d   = S_CAPTURE;
            ovf_d     = 1'b0;
            tmo_err_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (hold_cnt_q == fdiv) begin
          rd_cnt_d   = rd_cnt_q + (N+1)'(1);
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 24'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (areset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      en_fft      <= 1'b0;
      cnt_fft     <= '0;
      enout       <= 1'b0;
      cnt_ram_out <= '0;
      frame_done  <= 1'b0;
      ovf         <= 1'b0;
      tmo_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      en_fft      <= en_fft_d;
      cnt_fft     <= cnt_fft_d;
      enout       <= enout_d;
      cnt_ram_out <= cnt_ram_out_d;
      frame_done  <= frame_done_d;
      ovf         <= ovf_d;
      tmo_err     <= tmo_err_d;
    end
  end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 Parameter: N, 9, log2 of frame length; frame = 2^N samples.
REQ-002 Parameter: fdiv, 24'd400000, hold count; each readout bin is held fdiv+1 clk cycles.
REQ-003 Parameter: TMO, 16'd4096, drain timeout in clk cycles.
REQ-004 clk  in  1  single system clock (40 MHz); all logic on its rising edge.
REQ-005 areset  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  single-cycle frame request.
REQ-007 cont  in  1  continuous mode: after readout, re-enter CAPTURE without start.
REQ-008 din_valid  in  1  ADC sample strobe.
REQ-009 fft_ovalid  in  1  FFT output sample valid.
REQ-010 fft_oidx  in  N  FFT output sample index.
REQ-011 en_fft  out  1  sample enable to FFT.
REQ-012 cnt_fft  out  N  input sample index to FFT.
REQ-013 ram_wea  out  1  output-RAM write enable.
REQ-014 ram_addr  out  N  output-RAM address.
REQ-015 enout  out  1  readout data valid.
REQ-016 cnt_ram_out  out  N  natural-order bin index aligned to RAM read data.
REQ-017 busy  out  1  state != IDLE.
REQ-018 frame_done  out  1  one-cycle pulse at end of readout.
REQ-019 ovf  out  1  sticky: sample dropped or start rejected.
REQ-020 tmo_err  out  1  sticky: drain timeout.

Function
REQ-021 States: IDLE, CAPTURE, DRAIN, READOUT; state register is 2 bits.
REQ-022 IDLE->CAPTURE on start=1 or cont=1; accepting the frame clears ovf and tmo_err on that cycle.
REQ-023 CAPTURE: each din_valid cycle drives en_fft=1 and cnt_fft=sample count, registered (1-cycle latency), then increments the count; en_fft=0 on cycles without din_valid.
REQ-024 CAPTURE->DRAIN on the din_valid cycle with count = 2^N-1; the count then wraps to 0.
REQ-025 DRAIN: ram_wea=fft_ovalid and ram_addr=fft_oidx, both combinational, same cycle.
REQ-026 DRAIN->READOUT on the fft_ovalid cycle with fft_oidx all ones; that write completes.
REQ-027 DRAIN timeout counter: resets on DRAIN entry and on every fft_ovalid; on reaching TMO, set tmo_err and go to IDLE with no readout and no frame_done.
REQ-028 READOUT: rd_cnt (N+1 bits) and hold_cnt (24 bits) start at 0; ram_addr = bit-reverse(rd_cnt[N-1:0]); ram_wea=0.
REQ-029 READOUT advance: on hold_cnt=fdiv, rd_cnt+1 and hold_cnt=0; otherwise hold_cnt+1.
REQ-030 READOUT exit: when rd_cnt[N]=1, pulse frame_done and go to CAPTURE if cont=1, else IDLE.
REQ-031 enout and cnt_ram_out are registered copies of (state=READOUT and rd_cnt[N]=0) and rd_cnt[N-1:0], so they align with the 1-cycle RAM read latency.
REQ-032 din_valid while in DRAIN or READOUT: the sample is dropped and ovf is set.
REQ-033 start while busy=1: ignored, and ovf is set.
REQ-034 fft_ovalid outside DRAIN: ignored; ram_wea stays 0.
REQ-035 cont deasserted mid-frame: the current frame completes, then the block returns to IDLE.
REQ-036 start and cont together in IDLE: one frame is accepted, with no ovf.

Reset
REQ-037 areset=1 at a clock edge: state=IDLE and all counters=0; en_fft, cnt_fft, enout, cnt_ram_out, frame_done, ovf and tmo_err=0 on the next cycle, from any state.
REQ-038 With state=IDLE, ram_wea=0 and ram_addr=0.
REQ-039 Reset asserted mid-READOUT or mid-DRAIN: no frame_done pulse and no further RAM writes.

Verification (N=4, fdiv=2, TMO=20)
REQ-040 start, then 16 consecutive din_valid -> cnt_fft 0..15 with en_fft=1, each 1 cycle after its strobe; state=DRAIN after the 16th.
REQ-041 DRAIN, fft_ovalid with fft_oidx 0..15 -> ram_wea=1 with ram_addr=fft_oidx on each cycle; READOUT after idx 15.
REQ-042 READOUT -> ram_addr sequence 0,8,4,12,2,...,15, each held 3 cycles; cnt_ram_out 0..15 with enout=1 for 48 cycles; frame_done 1 cycle; busy=0 after.
REQ-043 cont=1 with a continuous stream -> back-to-back frames with no IDLE cycle; din_valid during READOUT -> ovf=1, which clears on the next frame accept.
REQ-044 DRAIN with no fft_ovalid for 20 cycles -> tmo_err=1, IDLE, no frame_done; start while busy -> ovf=1 and the state is unchanged.
REQ-045 areset pulsed mid-READOUT -> the next cycle shows all outputs 0 and IDLE; a following start captures a fresh frame from cnt_fft=0.
